altivec_issue_ctrl: RTL and testbench

- Issue controller in front of the altivec_dut execution core.
- Buffers instruction requests in a small FIFO and drives one instruction at a time into the DUT operand, opcode and go ports.
- Waits for the DUT to finish, using dut_busy and a minimum-latency window, then returns vrt to the requester with the request tag.
- Enforces single-outstanding operation and a timeout watchdog; sits between the stimulus/dispatch layer and the DUT.

---
 rtl/altivec_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_altivec_issue_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altivec_issue_ctrl.sv
// Issue controller in front of the altivec_dut execution core.
//
// Requests are buffered in a DEPTH-entry FIFO. One instruction at a time is
// popped, registered onto the DUT operand/opcode ports and started with a
// one-cycle pulse on go1/go2/go3. The controller then waits for dut_busy to
// drop, but no earlier than MIN_LAT cycles after the pulse. It returns the
// captured vrt with the request tag on the result port. A watchdog abandons
// the operation after TIMEOUT wait cycles. Target unit 3 is illegal and is
// answered immediately with an error result.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready = FIFO not full)
//   req_ins/rc/unit/tag       opcode, record bit, target go line, tag
//   req_vra/vrb/vrc           128-bit operands
//   res_valid/res_ready       result handshake
//   res_tag/data/err          tag, captured vrt, timeout/illegal-unit flag
//   vra/vrb/vrc/ins/rc        registered operands and opcode to the DUT
//   go1/go2/go3               registered start pulses to the DUT
//   dut_busy, vrt             DUT status and result
//   fifo_count                FIFO occupancy
module altivec_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MIN_LAT = 1,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_ins,
  input  logic                     req_rc,
  input  logic [1:0]               req_unit,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [127:0]             req_vra,
  input  logic [127:0]             req_vrb,
  input  logic [127:0]             req_vrc,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TAG_W-1:0]         res_tag,
  output logic [127:0]             res_data,
  output logic                     res_err,
  output logic [127:0]             vra,
  output logic [127:0]             vrb,
  output logic [127:0]             vrc,
  output logic [7:0]               ins,
  output logic                     rc,
  output logic                     go1,
  output logic                     go2,
  output logic                     go3,
  input  logic                     dut_busy,
  input  logic [127:0]             vrt,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CntW = PW + 1;
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
  localparam logic [CW-1:0]   MinLat    = CW'(MIN_LAT);
  localparam logic [CW-1:0]   LastWait  = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [127:0]     vra;
    logic [127:0]     vrb;
    logic [127:0]     vrc;
    logic [7:0]       ins;
    logic             rc;
    logic [1:0]       dest;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign req_ready = (fifo_count != FullCount);
  assign push      = req_valid && req_ready;
  // ISSUE is only entered with a non-empty FIFO, so the pop is always legal.
  assign pop       = (state == StIssue);
  assign head      = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{vra: req_vra, vrb: req_vrb, vrc: req_vrc, ins: req_ins,
                       rc: req_rc, dest: req_unit, tag: req_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      state      <= StIdle;
      cnt        <= '0;
      go1        <= 1'b0;
      go2        <= 1'b0;
      go3        <= 1'b0;
      vra        <= '0;
      vrb        <= '0;
      vrc        <= '0;
      ins        <= '0;
      rc         <= 1'b0;
      res_valid  <= 1'b0;
      res_tag    <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Go lines are single-cycle pulses; only ISSUE can raise one.
      go1 <= 1'b0;
      go2 <= 1'b0;
      go3 <= 1'b0;

      unique case (state)
        StIdle: begin
          if ((fifo_count != '0) && !dut_busy) state <= StIssue;
        end
        StIssue: begin
          vra     <= head.vra;
          vrb     <= head.vrb;
          vrc     <= head.vrc;
          ins     <= head.ins;
          rc      <= head.rc;
          res_tag <= head.tag;
          cnt     <= '0;
          if (head.dest == 2'd3) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= StResp;
          end else begin
            go1   <= (head.dest == 2'd0);
            go2   <= (head.dest == 2'd1);
            go3   <= (head.dest == 2'd2);
            state <= StWait;
          end
        end
        StWait: begin
          // Completion is tested first so it wins over a coincident timeout.
          if (!dut_busy && (cnt >= MinLat)) begin
            res_data  <= vrt;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= StResp;
          end else if (cnt == LastWait) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= StResp;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StResp: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_altivec_issue_ctrl.sv
// Self-checking bench for altivec_issue_ctrl with a transaction-level model
// and a behavioural stand-in for the execution core.
module tb_altivec_issue_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned MIN_LAT = 1;
  localparam int unsigned TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [7:0]         req_ins;
  logic               req_rc;
  logic [1:0]         req_unit;
  logic [TAG_W-1:0]   req_tag;
  logic [127:0]       req_vra, req_vrb, req_vrc;
  logic               res_valid;
  logic               res_ready;
  logic [TAG_W-1:0]   res_tag;
  logic [127:0]       res_data;
  logic               res_err;
  logic [127:0]       vra, vrb, vrc;
  logic [7:0]         ins;
  logic               rc;
  logic               go1, go2, go3;
  logic               dut_busy;
  logic [127:0]       vrt;
  logic [$clog2(DEPTH):0] fifo_count;

  altivec_issue_ctrl #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ins(req_ins),
    .req_rc(req_rc), .req_unit(req_unit), .req_tag(req_tag),
    .req_vra(req_vra), .req_vrb(req_vrb), .req_vrc(req_vrc),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .res_err(res_err),
    .vra(vra), .vrb(vrb), .vrc(vrc), .ins(ins), .rc(rc),
    .go1(go1), .go2(go2), .go3(go3),
    .dut_busy(dut_busy), .vrt(vrt), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PatA5 = {16{8'hA5}};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [127:0]     a, b, c;
    logic [7:0]       op;
    logic             rc;
    logic [1:0]       dest;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
    logic             err;
  } res_t;

  // Operation lifecycle: 0 idle, 1 issuing, 2 running on the core, 3 answering.
  req_t             m_q[$];
  int               m_phase;
  int               m_age;
  logic [2:0]       e_go;
  logic             e_res_valid, e_res_err;
  logic [127:0]     e_res_data;
  logic [TAG_W-1:0] e_res_tag;
  logic [127:0]     e_vra, e_vrb, e_vrc;
  logic [7:0]       e_ins;
  logic             e_rc;

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_age = 0; e_go = '0;
    e_res_valid = 0; e_res_err = 0; e_res_data = '0; e_res_tag = '0;
    e_vra = '0; e_vrb = '0; e_vrc = '0; e_ins = '0; e_rc = 0;
  endtask

  task automatic model_step();
    bit   accept;
    req_t r;
    accept = req_valid && (m_q.size() < DEPTH);
    e_go = '0;
    case (m_phase)
      0: if (m_q.size() > 0 && !dut_busy) m_phase = 1;
      1: begin
        r = m_q.pop_front();
        e_vra = r.a; e_vrb = r.b; e_vrc = r.c; e_ins = r.op; e_rc = r.rc;
        e_res_tag = r.tag;
        m_age = 0;
        if (r.dest == 2'd3) begin
          e_res_valid = 1; e_res_err = 1; e_res_data = '0; m_phase = 3;
        end else begin
          e_go[r.dest] = 1'b1; m_phase = 2;
        end
      end
      2: begin
        if (!dut_busy && m_age >= MIN_LAT) begin
          e_res_valid = 1; e_res_err = 0; e_res_data = vrt; m_phase = 3;
        end else if (m_age == TIMEOUT - 1) begin
          e_res_valid = 1; e_res_err = 1; e_res_data = '0; m_phase = 3;
        end else begin
          m_age++;
        end
      end
      3: if (res_ready) begin e_res_valid = 0; m_phase = 0; end
      default: m_phase = 0;
    endcase
    if (accept) begin
      r.a = req_vra; r.b = req_vrb; r.c = req_vrc; r.op = req_ins; r.rc = req_rc;
      r.dest = req_unit; r.tag = req_tag;
      m_q.push_back(r);
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Cycle-by-cycle compare, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("req_ready", req_ready, (m_q.size() < DEPTH));
      check("fifo_count", fifo_count, m_q.size());
      check("go", {go3, go2, go1}, e_go);
      check("res_valid", res_valid, e_res_valid);
      if (e_res_valid) begin
        check("res_tag", res_tag, e_res_tag);
        check("res_data", res_data, e_res_data);
        check("res_err", res_err, e_res_err);
      end
      check("vra", vra, e_vra);
      check("vrb", vrb, e_vrb);
      check("vrc", vrc, e_vrc);
      check("ins", ins, e_ins);
      check("rc", rc, e_rc);
    end
  end

  // ---------------- execution-core stand-in and result sink ----------------
  bit   hang = 0, busy_rand = 0, fixed_vrt = 0, rr_hold = 0, rr_rand = 0;
  int   busy_len = 0;
  int   left = 0;
  int   n_go1 = 0, n_go2 = 0, n_go3 = 0;
  res_t log_q[$];

  always @(negedge clk) begin
    if (rst) begin
      dut_busy = 0; left = 0;
    end else if (hang) begin
      dut_busy = 1;
    end else if (go1 || go2 || go3) begin
      left = busy_rand ? int'($urandom_range(0, 4)) : busy_len;
      dut_busy = (left > 0);
    end else if (left > 0) begin
      left--;
      dut_busy = (left > 0);
    end else begin
      dut_busy = 0;
    end
    vrt = fixed_vrt ? PatA5 : {$urandom, $urandom, $urandom, $urandom};
    res_ready = rr_hold ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (!rst) begin
      if (go1) n_go1++;
      if (go2) n_go2++;
      if (go3) n_go3++;
      if (res_valid && res_ready) log_q.push_back('{tag: res_tag, data: res_data, err: res_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] u, input logic [TAG_W-1:0] t, input logic [7:0] op);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1; req_unit = u; req_tag = t; req_ins = op; req_rc = 1'($urandom);
    req_vra = {$urandom, $urandom, $urandom, $urandom};
    req_vrb = {$urandom, $urandom, $urandom, $urandom};
    req_vrc = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 req_valid = 0;
    if (!ok) check("send_accept", 0, 1);
  endtask

  task automatic wait_log(input int n, input string name);
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (log_q.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check(name, log_q.size(), n);
  endtask

  task automatic wait_go(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (go1 || go2 || go3) begin ok = 1; break; end
    end
    if (!ok) check(name, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, gsum;
    logic [1:0] u;
    rst = 1; req_valid = 0; req_ins = '0; req_rc = 0; req_unit = '0; req_tag = '0;
    req_vra = '0; req_vrb = '0; req_vrc = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_go", {go3, go2, go1}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_vra", vra, 0);
    rst = 0;

    // Single op: unit 0, tag 5, core busy 3 cycles, result A5..A5.
    fixed_vrt = 1; busy_len = 3;
    send(2'd0, 4'd5, 8'h10);
    wait_log(1, "single_result");
    repeat (3) @(negedge clk);
    if (log_q.size() >= 1) begin
      check("single_tag", log_q[0].tag, 5);
      check("single_data", log_q[0].data, PatA5);
      check("single_err", log_q[0].err, 0);
    end
    check("single_go1_pulses", n_go1, 1);
    check("single_other_go", n_go2 + n_go3, 0);

    // Back-pressure: core busy, four requests fill the FIFO, fifth stalls.
    fixed_vrt = 0; busy_len = 2; hang = 1;
    base = log_q.size();
    for (int i = 0; i < 4; i++) send(2'(i % 3), TAG_W'(i), 8'(8'h40 + i));
    @(negedge clk);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_req_ready", req_ready, 0);
    hang = 0;
    send(2'd1, 4'd4, 8'h44);
    wait_log(base + 5, "bp_results");
    for (int i = 0; i < 5; i++)
      if (log_q.size() > base + i) check("bp_order_tag", log_q[base + i].tag, i);

    // Timeout: core never finishes; next queued request runs afterwards.
    repeat (3) @(negedge clk);
    base = log_q.size(); busy_len = 5;
    send(2'd1, 4'd7, 8'h22);
    send(2'd2, 4'd8, 8'h23);
    wait_go("timeout_go");
    hang = 1;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); k++;
      if (res_valid) break;
    end
    check("timeout_latency", k, TIMEOUT);
    hang = 0;
    wait_log(base + 2, "timeout_results");
    if (log_q.size() >= base + 2) begin
      check("timeout_tag", log_q[base].tag, 7);
      check("timeout_err", log_q[base].err, 1);
      check("timeout_data", log_q[base].data, 0);
      check("after_timeout_tag", log_q[base + 1].tag, 8);
      check("after_timeout_err", log_q[base + 1].err, 0);
    end

    // Illegal unit 3: no go pulse, error result with tag 2.
    repeat (3) @(negedge clk);
    base = log_q.size(); gsum = n_go1 + n_go2 + n_go3;
    send(2'd3, 4'd2, 8'h55);
    wait_log(base + 1, "illegal_result");
    repeat (2) @(negedge clk);
    check("illegal_no_go", n_go1 + n_go2 + n_go3, gsum);
    if (log_q.size() >= base + 1) begin
      check("illegal_tag", log_q[base].tag, 2);
      check("illegal_err", log_q[base].err, 1);
      check("illegal_data", log_q[base].data, 0);
    end

    // Result back-pressure: res_ready low for 10 cycles.
    base = log_q.size(); rr_hold = 1; fixed_vrt = 1; busy_len = 1;
    send(2'd0, 4'd9, 8'h66);
    send(2'd1, 4'd10, 8'h67);
    k = 0;
    while (!res_valid && k < 200) begin @(negedge clk); k++; end
    gsum = n_go1 + n_go2 + n_go3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_tag", res_tag, 9);
      check("hold_data", res_data, PatA5);
      check("hold_err", res_err, 0);
    end
    check("hold_no_go", n_go1 + n_go2 + n_go3, gsum);
    rr_hold = 0;
    wait_log(base + 2, "hold_results");
    if (log_q.size() >= base + 2) begin
      check("hold_first_tag", log_q[base].tag, 9);
      check("hold_second_tag", log_q[base + 1].tag, 10);
    end

    // Randomised traffic against the model.
    fixed_vrt = 0; busy_rand = 1; rr_rand = 1;
    base = log_q.size();
    for (int n = 0; n < 40; n++) begin
      u = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(u, TAG_W'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 3000; i++) begin
      if (m_q.size() == 0 && m_phase == 0) break;
      @(negedge clk);
    end
    check("random_result_count", log_q.size() - base, 40);

    // Reset in the middle of a wait discards the op and the queue.
    busy_rand = 0; rr_rand = 0; busy_len = 8;
    send(2'd0, 4'd11, 8'h77);
    send(2'd1, 4'd12, 8'h78);
    repeat (3) @(negedge clk);
    base = log_q.size();
    rst = 1;
    #1;
    check("arst_go", {go3, go2, go1}, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_vra", vra, 0);
    check("arst_ins", ins, 0);
    check("arst_fifo_count", fifo_count, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_res_tag", res_tag, 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("post_rst_fifo_count", fifo_count, 0);
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_no_result", log_q.size(), base);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
